// File: rtl/nibble_serial_adder_ctrl_if.sv
// Start/busy/done handshake and operand/result bundle
// for the nibble-serial adder sequencer.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf, zero
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf, zero
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract over one shared 4-bit CLA slice,
// LSB nibble first, carry chained through a register.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input logic                      clk,
    input logic                      rst,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("WIDTH must be a multiple of 4 and at least 8");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_sum;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [4:0]       w_slice;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_accept;
    logic             w_last;

    // Lookahead carries are flattened so the slice stays two levels deep.
    function automatic logic [4:0] cla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       c0
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign w_a_nib  = r_a[{r_k, 2'b00} +: 4];
    assign w_b_nib  = r_b[{r_k, 2'b00} +: 4];
    assign w_slice  = cla4(w_a_nib, w_b_nib, r_carry);
    assign w_last   = (r_k == K_LAST);
    assign w_accept = bus.start
                    && (r_state == S_IDLE || r_state == S_DONE);

    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[{r_k, 2'b00} +: 4] = w_slice[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_sum   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        // Subtract as A + ~B + 1; cin becomes borrow-in.
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.cin ^ bus.sub;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_slice[4];
                    r_k     <= r_k + KW'(1);
                    if (w_last) begin
                        r_cout  <= w_slice[4];
                        r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1])
                                && (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);
                        r_zero  <= (w_sum_next == '0);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;
endmodule
